// File: rtl/pid_step_sequencer.sv
// rtl/pid_step_sequencer.sv - initiator-side step sequencer for bilinear PID/transfer-function responders
// Optional done timeout: define PID_SEQ_DONE_TIMEOUT_EN.
module pid_step_sequencer #(
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              pid_rst_user,
    output logic              pid_sta,
    output logic [DATA_W-1:0] pid_x,
    output logic              pid_cvs,
    input  logic              pid_done,
    input  logic [DATA_W-1:0] pid_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic [CNT_W-1:0]  step_cnt,
    output logic              err
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] INIT      = 3'd1;
    localparam logic [2:0] WAIT_IN   = 3'd2;
    localparam logic [2:0] ISSUE     = 3'd3;
    localparam logic [2:0] WAIT_DONE = 3'd4;
    localparam logic [2:0] COMMIT    = 3'd5;

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic              r_first_step;
    logic              r_pid_rst_user;
    logic              r_pid_sta;
    logic              r_pid_cvs;
    logic [DATA_W-1:0] r_pid_x;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [CNT_W-1:0]  r_step_cnt;
    logic              w_in_ready;
    logic              w_in_xfer;
    logic              w_capture;

`ifdef PID_SEQ_DONE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            r_err;
    logic            w_timeout;
`endif

    // run_start has priority over any upstream transfer in the same cycle
    assign w_in_ready = (r_state == WAIT_IN) && !(r_out_valid && !out_ready) && !run_start;
    assign w_in_xfer  = in_valid && w_in_ready;
    assign w_capture  = (r_state == WAIT_DONE) && pid_done && !run_start;

    always_comb begin
        w_next = r_state;
`ifdef PID_SEQ_DONE_TIMEOUT_EN
        w_timeout = 1'b0;
`endif
        case (r_state)
            IDLE:      if (run_start) w_next = INIT;
            INIT:      w_next = WAIT_IN;
            WAIT_IN:   if (w_in_xfer) w_next = ISSUE;
            ISSUE:     w_next = WAIT_DONE;
            WAIT_DONE: begin
                if (pid_done) begin
                    w_next = COMMIT;
                end
`ifdef PID_SEQ_DONE_TIMEOUT_EN
                else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
                    w_next    = IDLE;
                    w_timeout = 1'b1;
                end
`endif
            end
            COMMIT:    w_next = WAIT_IN;
            default:   w_next = IDLE;
        endcase
        if (run_start) begin
            w_next = INIT;
`ifdef PID_SEQ_DONE_TIMEOUT_EN
            w_timeout = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_first_step   <= 1'b1;
            r_pid_rst_user <= 1'b0;
            r_pid_sta      <= 1'b0;
            r_pid_cvs      <= 1'b0;
            r_pid_x        <= '0;
            r_out_valid    <= 1'b0;
            r_out_data     <= '0;
            r_step_cnt     <= '0;
        end else begin
            r_state <= w_next;
            // pulses are decoded from the next state so they line up with the state they belong to
            r_pid_rst_user <= (w_next == INIT);
            r_pid_sta      <= (w_next == ISSUE);
            r_pid_cvs      <= ((w_next == ISSUE) && r_first_step) || (w_next == COMMIT);

            if (w_next == INIT) begin
                r_first_step <= 1'b1;
            end else if (r_state == COMMIT) begin
                r_first_step <= 1'b0;
            end

            if (w_next == INIT) begin
                r_step_cnt <= '0;
            end else if (r_state == COMMIT) begin
                r_step_cnt <= r_step_cnt + 1'b1;
            end

            if (w_in_xfer) begin
                r_pid_x <= in_data;
            end

            // capture beats a same-cycle downstream handshake
            if (run_start && (r_state != IDLE)) begin
                r_out_valid <= 1'b0;
            end else if (w_capture) begin
                r_out_valid <= 1'b1;
                r_out_data  <= pid_y;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef PID_SEQ_DONE_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (r_state == WAIT_DONE) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end else begin
                r_to_cnt <= '0;
            end
            if (w_next == INIT) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign in_ready     = w_in_ready;
    assign pid_rst_user = r_pid_rst_user;
    assign pid_sta      = r_pid_sta;
    assign pid_cvs      = r_pid_cvs;
    assign pid_x        = r_pid_x;
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign busy         = (r_state != IDLE);
    assign step_cnt     = r_step_cnt;

endmodule

// File: tb/tb_pid_step_sequencer.sv
// tb/tb_pid_step_sequencer.sv - directed self-checking bench for pid_step_sequencer
module tb_pid_step_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        run_start;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        pid_rst_user;
    logic        pid_sta;
    logic [31:0] pid_x;
    logic        pid_cvs;
    logic        pid_done;
    logic [31:0] pid_y;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;
    logic [1:0]  step_cnt;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pid_step_sequencer #(.DATA_W(32), .CNT_W(2), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .run_start(run_start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .pid_rst_user(pid_rst_user), .pid_sta(pid_sta), .pid_x(pid_x), .pid_cvs(pid_cvs),
        .pid_done(pid_done), .pid_y(pid_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .step_cnt(step_cnt), .err(err)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // precondition: DUT in WAIT_IN; responder answers 3 cycles after sta
    task automatic do_step(input logic [31:0] d, input logic [31:0] y, input logic exp_cvs);
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("step_sta", {31'd0, pid_sta}, 32'd1);
        chk("step_issue_cvs", {31'd0, pid_cvs}, {31'd0, exp_cvs});
        repeat (3) tick();
        pid_done = 1'b1;
        pid_y    = y;
        tick();
        pid_done = 1'b0;
        chk("step_out_data", out_data, y);
        tick();
    endtask

    initial begin
        rst       = 1'b0;
        run_start = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        pid_done  = 1'b0;
        pid_y     = '0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_step_cnt", {30'd0, step_cnt}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_pid_x", pid_x, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_pulses", {29'd0, pid_rst_user, pid_sta, pid_cvs}, 32'd0);
        rst = 1'b1;
        tick();

        // IDLE ignores in_valid; run_start enters INIT
        in_valid  = 1'b1;
        in_data   = 32'hDEAD_BEEF;
        #1 chk("idle_in_ready", {31'd0, in_ready}, 32'd0);
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        in_valid  = 1'b0;
        chk("init_rst_user", {31'd0, pid_rst_user}, 32'd1);
        chk("init_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("waitin_rst_user_low", {31'd0, pid_rst_user}, 32'd0);
        chk("waitin_in_ready", {31'd0, in_ready}, 32'd1);
        chk("waitin_step_cnt", {30'd0, step_cnt}, 32'd0);
        chk("waitin_pid_x", pid_x, 32'd0);

        // first sample, done 21 cycles after sta
        in_valid = 1'b1;
        in_data  = 32'h3F80_0000;
        tick();
        in_valid = 1'b0;
        chk("s1_sta", {31'd0, pid_sta}, 32'd1);
        chk("s1_cvs_first", {31'd0, pid_cvs}, 32'd1);
        chk("s1_pid_x", pid_x, 32'h3F80_0000);
        tick();
        chk("s1_wait_pulses", {30'd0, pid_sta, pid_cvs}, 32'd0);
        repeat (20) tick();
        pid_done = 1'b1;
        pid_y    = 32'h4000_0000;
        chk("s1_out_valid_pre", {31'd0, out_valid}, 32'd0);
        tick();
        pid_done = 1'b0;
        pid_y    = 32'h1234_5678;
        chk("s1_out_valid", {31'd0, out_valid}, 32'd1);
        chk("s1_out_data", out_data, 32'h4000_0000);
        chk("s1_commit_cvs", {31'd0, pid_cvs}, 32'd1);
        tick();
        chk("s1_step_cnt", {30'd0, step_cnt}, 32'd1);
        chk("s1_cvs_low", {31'd0, pid_cvs}, 32'd0);

        // second sample blocked by undrained output
        in_valid = 1'b1;
        in_data  = 32'h4040_0000;
        #1 chk("s2_blocked", {31'd0, in_ready}, 32'd0);
        tick();
        tick();
        chk("s2_blocked_late", {31'd0, in_ready}, 32'd0);
        chk("s2_no_sta", {31'd0, pid_sta}, 32'd0);
        chk("s2_pid_x_held", pid_x, 32'h3F80_0000);
        out_ready = 1'b1;
        #1 chk("s2_unblocked", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("s2_out_valid_drained", {31'd0, out_valid}, 32'd0);
        chk("s2_sta", {31'd0, pid_sta}, 32'd1);
        chk("s2_no_issue_cvs", {31'd0, pid_cvs}, 32'd0);
        chk("s2_pid_x", pid_x, 32'h4040_0000);
        tick();
        pid_done = 1'b1;
        pid_y    = 32'h4080_0000;
        tick();
        pid_done = 1'b0;
        chk("s2_out_data", out_data, 32'h4080_0000);
        chk("s2_out_valid", {31'd0, out_valid}, 32'd1);
        tick();
        chk("s2_step_cnt", {30'd0, step_cnt}, 32'd2);

        // abort in WAIT_DONE, then a late done
        in_valid  = 1'b1;
        in_data   = 32'h40A0_0000;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        chk("abort_rst_user", {31'd0, pid_rst_user}, 32'd1);
        chk("abort_step_cnt", {30'd0, step_cnt}, 32'd0);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        pid_done = 1'b1;
        pid_y    = 32'h0BAD_0BAD;
        tick();
        pid_done = 1'b0;
        chk("late_done_no_valid", {31'd0, out_valid}, 32'd0);
        chk("late_done_no_capture", out_data, 32'h4080_0000);
        tick();
        chk("late_done_no_commit", {30'd0, step_cnt}, 32'd0);
        chk("late_done_in_ready", {31'd0, in_ready}, 32'd1);

        // step counter wraps at all-ones (CNT_W = 2)
        do_step(32'h3F00_0000, 32'h3E00_0000, 1'b1);
        chk("wrap_cnt1", {30'd0, step_cnt}, 32'd1);
        do_step(32'h3F00_0001, 32'h3E00_0001, 1'b0);
        chk("wrap_cnt2", {30'd0, step_cnt}, 32'd2);
        do_step(32'h3F00_0002, 32'h3E00_0002, 1'b0);
        chk("wrap_cnt3", {30'd0, step_cnt}, 32'd3);
        do_step(32'h3F00_0003, 32'h3E00_0003, 1'b0);
        chk("wrap_cnt0", {30'd0, step_cnt}, 32'd0);

        // run_start and in_valid together: run_start wins
        in_valid  = 1'b1;
        in_data   = 32'h4100_0000;
        run_start = 1'b1;
        #1 chk("race_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        run_start = 1'b0;
        in_valid  = 1'b0;
        chk("race_no_sta", {31'd0, pid_sta}, 32'd0);
        chk("race_rst_user", {31'd0, pid_rst_user}, 32'd1);
        chk("race_pid_x", pid_x, 32'h3F00_0003);
        tick();

        // withheld done
        in_valid  = 1'b1;
        in_data   = 32'h4110_0000;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        repeat (63) tick();
        chk("to_busy_before", {31'd0, busy}, 32'd1);
        chk("to_err_before", {31'd0, err}, 32'd0);
        tick();
`ifdef PID_SEQ_DONE_TIMEOUT_EN
        chk("to_busy_after", {31'd0, busy}, 32'd0);
        chk("to_err_after", {31'd0, err}, 32'd1);
`else
        chk("to_busy_after", {31'd0, busy}, 32'd1);
        chk("to_err_after", {31'd0, err}, 32'd0);
`endif
        repeat (40) tick();
`ifdef PID_SEQ_DONE_TIMEOUT_EN
        chk("to_err_sticky", {31'd0, err}, 32'd1);
`else
        chk("to_busy_held", {31'd0, busy}, 32'd1);
`endif
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        chk("restart_err_clear", {31'd0, err}, 32'd0);
        chk("restart_rst_user", {31'd0, pid_rst_user}, 32'd1);
        tick();
        chk("restart_in_ready", {31'd0, in_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pid_step_sequencer.md
Name: pid_step_sequencer

Overview:
- Initiator-side controller for the bilinear PID/transfer-function responder blocks (sta / x / done_sig / y / control_valuation_sig / rst_user interface).
- Accepts input samples from an upstream valid/ready stream and issues one solver step per sample.
- Waits for the block's done pulse, captures y, commits the step state, and presents y on a downstream valid/ready stream.
- Owns run initialisation: the rst_user pulse and the first-step arming of initial-value loading.

Parameters:
DATA_W, 32, sample width (IEEE-754 single).
CNT_W, 16, width of the step counter.
TIMEOUT, 64, max cycles in WAIT_DONE before error (only with the optional feature).

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-low reset.
run_start  input  1  single-cycle pulse; begins a new run (re-initialises the responder).
in_valid  input  1  upstream sample valid.
in_ready  output  1  upstream ready; transfer occurs when in_valid && in_ready.
in_data  input  DATA_W  upstream sample.
pid_rst_user  output  1  to responder rst_user.
pid_sta  output  1  to responder sta; step start pulse.
pid_x  output  DATA_W  to responder x; held stable from ISSUE until the next accepted sample.
pid_cvs  output  1  to responder control_valuation_sig.
pid_done  input  1  from responder done_sig.
pid_y  input  DATA_W  from responder y.
out_valid  output  1  downstream result valid.
out_ready  input  1  downstream ready.
out_data  output  DATA_W  captured y.
busy  output  1  high in every state except IDLE.
step_cnt  output  CNT_W  completed steps in the current run.
err  output  1  sticky timeout flag (0 when the feature is compiled out).

Behaviour:
- Reset (rst = 0, asynchronous): state IDLE. All outputs 0, including pid_x, out_data, step_cnt, err. The internal first_step flag is set to 1.
- States: IDLE, INIT, WAIT_IN, ISSUE, WAIT_DONE, COMMIT.
- IDLE: in_ready = 0, and in_valid is ignored. On run_start go to INIT.
- INIT (1 cycle):
  - pid_rst_user = 1.
  - Set first_step = 1, step_cnt = 0, err = 0.
  - Go to WAIT_IN.
- WAIT_IN:
  - in_ready = 1 only when !(out_valid && !out_ready), so the output holding register is never overwritten.
  - On a transfer, register in_data into pid_x and go to ISSUE.
- ISSUE (1 cycle):
  - pid_sta = 1.
  - If first_step = 1, pid_cvs = 1 in the same cycle; this arms initial-value loading in the responder.
  - Go to WAIT_DONE.
- WAIT_DONE: hold pid_x. On the pid_done cycle:
  - Capture pid_y into out_data.
  - Set out_valid = 1.
  - Go to COMMIT.
- COMMIT (1 cycle):
  - pid_cvs = 1, which stores x and y history in the responder.
  - Clear first_step.
  - step_cnt += 1, wrapping from all-ones to 0.
  - Go to WAIT_IN.
- Output stream: out_valid stays high until a cycle with out_valid && out_ready, then clears in that cycle. If a capture and an out_ready handshake occur in the same cycle, the capture wins: out_valid stays 1 with the new data.
- Latency: sample accept → pid_sta is 1 cycle. pid_done → out_valid is 1 cycle.
- Throughput: 1 sample per (responder latency + 3) cycles.
- pid_done outside WAIT_DONE is ignored.
- run_start in any non-IDLE state aborts the current step:
  - Go to INIT next cycle.
  - out_valid is cleared.
  - Any pending pid_done from the aborted step is ignored, because the state is not WAIT_DONE.
- run_start and an in_valid transfer in the same cycle: run_start wins, and the sample is not accepted (in_ready is forced 0 that cycle).
- All pulse outputs (pid_rst_user, pid_sta, pid_cvs) are registered and last exactly 1 cycle.

Optional Feature:
- Macro PID_SEQ_DONE_TIMEOUT_EN.
- When defined:
  - A cycle counter runs in WAIT_DONE.
  - If TIMEOUT cycles elapse without pid_done, set err = 1 (sticky), drop to IDLE, and leave out_valid unchanged.
  - err clears only in INIT.
- When undefined: WAIT_DONE waits indefinitely, err is tied to 0, and no counter logic is present.

Test Plan:
- Reset released, run_start pulse → pid_rst_user high exactly 1 cycle, then in_ready = 1, busy = 1, step_cnt = 0.
- First sample 0x3F800000, responder model with done 21 cycles after sta returning y = 0x40000000:
  - pid_sta and pid_cvs high together on the cycle after accept.
  - out_data = 0x40000000 and out_valid = 1 one cycle after done.
  - pid_cvs pulses again in COMMIT.
  - step_cnt = 1.
- Second sample with out_ready held low → in_ready stays 0 until out_ready = 1 for one cycle. Second step then issues, with no pid_cvs in ISSUE (first_step cleared).
- run_start asserted in WAIT_DONE mid-step:
  - Next cycle INIT with a pid_rst_user pulse, out_valid = 0, step_cnt = 0.
  - A late pid_done produces no capture.
- Force step_cnt to all-ones and complete one step → step_cnt wraps to 0.
- With PID_SEQ_DONE_TIMEOUT_EN and TIMEOUT = 64, withhold pid_done:
  - err = 1 and state IDLE after 64 cycles, busy = 0.
  - Next run_start clears err.
  - Without the macro, err stays 0 and busy stays 1 indefinitely.
